// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// buffers {pc, instr} pairs in a 2-entry FIFO for decode, with redirect and halt support.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [6:0]  HALT_OPCODE = 7'h7F
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {S_FETCH = 1'b0, S_HALTED = 1'b1} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_halted;
  logic [15:0] r_q_pc    [0:1];
  logic [15:0] r_q_instr [0:1];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_tail;
  logic [15:0] w_head_pc;
  logic [15:0] w_head_instr;

  assign w_valid      = (r_count != 2'd0);
  assign w_head_pc    = r_q_pc[r_head];
  assign w_head_instr = r_q_instr[r_head];

  // With two slots the tail is head for count 0 or 2 (the latter only when popping).
  assign w_tail = r_head ^ r_count[0];
  assign w_pop  = w_valid & out_ready & ~redirect_valid;
  assign w_push = (r_state == S_FETCH) & ~redirect_valid & ((r_count < 2'd2) | w_pop);

  assign imem_addr = r_pc;
  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_head_pc : 16'h0000;
  assign out_instr = w_valid ? w_head_instr : 16'h0000;
  assign halted    = r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_count  <= 2'd0;
      r_head   <= 1'b0;
      r_state  <= S_FETCH;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_count  <= 2'd0;
      r_head   <= 1'b0;
      r_state  <= S_FETCH;
      r_halted <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc <= r_pc + 16'd1;
        if (imem_data[15:9] == HALT_OPCODE) begin
          r_state <= S_HALTED;
        end
      end
      if (w_pop) begin
        r_head <= ~r_head;
        if (w_head_instr[15:9] == HALT_OPCODE) begin
          r_halted <= 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload slots need no reset: they are masked by the count until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[w_tail]    <= r_pc;
      r_q_instr[w_tail] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: scenario tasks with inline checks against
// hand-computed PCs and instruction words from a simple instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;
  logic        halt_en = 1'b0;

  int tests = 0;
  int fails = 0;

  fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(7'h7F)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // imem[i] = 0x0100 + i, with an optional halt word planted at address 3
  assign imem_data = (halt_en && imem_addr == 16'h0003) ? 16'hFE00 : 16'h0100 + imem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests++; if (out_pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h expected 0000", out_pc); end
    tests++; if (out_instr !== 16'h0000) begin fails++; $display("FAIL reset_instr: got %h expected 0000", out_instr); end
    tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    $display("[TB] reset: valid=%b addr=%h halted=%b", out_valid, imem_addr, halted);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      tests++; if (out_pc !== 16'(i)) begin fails++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 16'(i)); end
      tests++; if (out_instr !== 16'h0100 + 16'(i)) begin fails++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, out_instr, 16'h0100 + 16'(i)); end
      $display("[TB] stream: pc=%h instr=%h", out_pc, out_instr);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    tests++; if (imem_addr !== 16'h0002) begin fails++; $display("FAIL bp_addr: got %h expected 0002", imem_addr); end
    tests++; if (out_pc !== 16'h0000 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_head: got pc=%h v=%b expected pc=0000 v=1", out_pc, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_pc !== 16'(i) || out_instr !== 16'h0100 + 16'(i)) begin fails++; $display("FAIL bp_drain[%0d]: got pc=%h instr=%h expected pc=%h", i, out_pc, out_instr, 16'(i)); end
      $display("[TB] backpressure drain: pc=%h instr=%h", out_pc, out_instr);
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    tests++; if (imem_addr !== 16'h0002) begin fails++; $display("FAIL redir_full: got addr=%h expected 0002", imem_addr); end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got valid=%b expected 0", out_valid); end
    tests++; if (imem_addr !== 16'h0040) begin fails++; $display("FAIL redir_addr: got %h expected 0040", imem_addr); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 16'h0140) begin fails++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=0040 instr=0140", out_valid, out_pc, out_instr); end
    $display("[TB] redirect: pc=%h instr=%h", out_pc, out_instr);
  endtask

  task automatic test_halt();
    out_ready = 1'b1;
    halt_en = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (out_pc !== 16'(i)) begin fails++; $display("FAIL halt_pc[%0d]: got %h expected %h", i, out_pc, 16'(i)); end
    end
    tests++; if (out_instr !== 16'hFE00) begin fails++; $display("FAIL halt_word: got %h expected FE00", out_instr); end
    tests++; if (imem_addr !== 16'h0004) begin fails++; $display("FAIL halt_addr: got %h expected 0004", imem_addr); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early: got %b expected 0", halted); end
    step();
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_set: got %b expected 1", halted); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b0 || imem_addr !== 16'h0004) begin fails++; $display("FAIL halt_stopped[%0d]: got v=%b addr=%h expected v=0 addr=0004", i, out_valid, imem_addr); end
      step();
    end
    $display("[TB] halt: halted=%b addr=%h", halted, imem_addr);
    halt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    step();
    redirect_valid = 1'b0;
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear: got %b expected 0", halted); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin fails++; $display("FAIL halt_resume: got v=%b pc=%h expected v=1 pc=0000", out_valid, out_pc); end
    step();
    tests++; if (out_pc !== 16'h0001) begin fails++; $display("FAIL halt_resume2: got pc=%h expected 0001", out_pc); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [0:3];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (out_pc !== exp_pc[i] || out_instr !== 16'h0100 + exp_pc[i]) begin fails++; $display("FAIL wrap[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i, out_pc, out_instr, exp_pc[i], 16'h0100 + exp_pc[i]); end
      $display("[TB] wrap: pc=%h instr=%h", out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back_reset();
    out_ready = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0 || imem_addr !== 16'h0000 || halted !== 1'b0) begin fails++; $display("FAIL midrst: got v=%b addr=%h h=%b expected v=0 addr=0000 h=0", out_valid, imem_addr, halted); end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b1 || out_pc !== 16'(i)) begin fails++; $display("FAIL midrst_run[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 16'(i)); end
    end
    $display("[TB] mid-run reset resumed at pc=%h", out_pc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
